led_uart_reporter: RTL and testbench



---
 rtl/led_uart_reporter.sv | 143 ++++++++++++++
 tb/tb_led_uart_reporter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_uart_reporter.sv
`default_nettype none
// ============================================================================
// led_uart_reporter : sends a 2-byte UART frame (HEADER_BYTE, leds) whenever
//                     the LED vector changes; in-flight changes are coalesced.
// Revision          : 1.0
// ============================================================================
module led_uart_reporter #(
   parameter int unsigned CLK_FREQ    = 25_000_000,
   parameter int unsigned BAUD_RATE   = 115_200,
   parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  leds_in,
   output logic        uart_tx,
   output logic        busy,
   output logic [15:0] frames_sent,
   output logic [7:0]  coalesced_cnt
);

   // CLKS_PER_BIT below 2 is not a supported configuration.
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int          CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic             byte_idx_q;
   logic [7:0]       leds_prev_q;
   logic [7:0]       snapshot_q;
   logic [7:0]       pend_val_q;
   logic             pending_q;
   logic             tx_q;
   logic             busy_q;
   logic [15:0]      frames_q;
   logic [7:0]       coal_q;

   logic             w_change;
   logic             w_coal_sat;
   logic [7:0]       w_tx_byte;

   assign w_change   = (leds_in != leds_prev_q);
   assign w_coal_sat = (coal_q == 8'hFF);
   assign w_tx_byte  = byte_idx_q ? snapshot_q : HEADER_BYTE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         byte_idx_q  <= 1'b0;
         leds_prev_q <= 8'h00;
         snapshot_q  <= 8'h00;
         pend_val_q  <= 8'h00;
         pending_q   <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         frames_q    <= 16'd0;
         coal_q      <= 8'd0;
      end else begin
         leds_prev_q <= leds_in;

         // A change while a frame is in flight never touches snapshot_q.
         if (state_q != S_IDLE && w_change) begin
            pend_val_q <= leds_in;
            pending_q  <= 1'b1;
            if (pending_q && !w_coal_sat) coal_q <= coal_q + 8'd1;
         end

         case (state_q)
            S_IDLE: begin
               if (w_change || pending_q) begin
                  snapshot_q <= w_change ? leds_in : pend_val_q;
                  pending_q  <= 1'b0;
                  if (w_change && pending_q && !w_coal_sat) coal_q <= coal_q + 8'd1;
                  state_q    <= S_START;
                  cnt_q      <= '0;
                  byte_idx_q <= 1'b0;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_START: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q     <= '0;
                  bit_idx_q <= 3'd0;
                  tx_q      <= w_tx_byte[0];
                  state_q   <= S_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx_q      <= w_tx_byte[bit_idx_q + 3'd1];
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (!byte_idx_q) begin
                     byte_idx_q <= 1'b1;
                     tx_q       <= 1'b0;
                     state_q    <= S_START;
                  end else begin
                     byte_idx_q <= 1'b0;
                     frames_q   <= frames_q + 16'd1;
                     busy_q     <= 1'b0;
                     state_q    <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign uart_tx       = tx_q;
   assign busy          = busy_q;
   assign frames_sent   = frames_q;
   assign coalesced_cnt = coal_q;

endmodule
`default_nettype wire

// File: tb/tb_led_uart_reporter.sv
`default_nettype none
// ============================================================================
// tb_led_uart_reporter : directed bench with a UART line decoder feeding a
//                        scoreboard of expected data bytes.
// Revision             : 1.0
// ============================================================================
module tb_led_uart_reporter;

   localparam int CPB = 10;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic [7:0]  leds = 8'h00;
   logic        uart_tx;
   logic        busy;
   logic [15:0] frames_sent;
   logic [7:0]  coalesced_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  sb[$];
   bit          sb_mode = 1'b0;
   bit          seen[256];
   logic [7:0]  last_rx = 8'h00;

   always #5 clk = ~clk;

   led_uart_reporter #(
      .CLK_FREQ   (1_000_000),
      .BAUD_RATE  (100_000),
      .HEADER_BYTE(8'hA5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .leds_in      (leds),
      .uart_tx      (uart_tx),
      .busy         (busy),
      .frames_sent  (frames_sent),
      .coalesced_cnt(coalesced_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      leds = 8'h00;
      tick(2);
      rst  = 1'b0;
   endtask

   // Line decoder: t counts falling clock edges from the first low sample,
   // so each bit is sampled in its middle.
   initial begin : rx_mon
      int         t;
      bit         active;
      bit         odd;
      logic [7:0] sh;
      t = 0; active = 1'b0; odd = 1'b0; sh = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 1'b0;
            odd    = 1'b0;
         end else if (!active) begin
            if (uart_tx === 1'b0) begin
               active = 1'b1;
               t      = 0;
            end
         end else begin
            t++;
            if (t == CPB / 2) begin
               check("start_bit", 32'(uart_tx), 0);
            end else if (t > CPB && t < 9 * CPB && (t % CPB) == CPB / 2) begin
               sh = {uart_tx, sh[7:1]};
            end else if (t == 9 * CPB + CPB / 2) begin
               check("stop_bit", 32'(uart_tx), 1);
               active = 1'b0;
               if (!odd) begin
                  check("header", 32'(sh), 'hA5);
               end else begin
                  last_rx = sh;
                  if (sb_mode) begin
                     check("held_value", 32'(seen[sh]), 1);
                  end else begin
                     check("sb_nonempty", 32'(sb.size() > 0), 1);
                     if (sb.size() > 0) check("data_byte", 32'(sh), 32'(sb.pop_front()));
                  end
               end
               odd = ~odd;
            end
         end
      end
   end

   initial begin : stim
      int         bad;
      int         quiet;
      int         waited;
      logic [7:0] v;
      logic [7:0] prev;

      // Reset state and long idle with a constant input.
      do_reset();
      check("rst_tx", 32'(uart_tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_frames", 32'(frames_sent), 0);
      check("rst_coal", 32'(coalesced_cnt), 0);
      bad = 0;
      repeat (500) begin
         tick(1);
         if (uart_tx !== 1'b1 || busy !== 1'b0 || frames_sent !== 16'd0) bad++;
      end
      check("idle_quiet", 32'(bad), 0);

      // Single change: latency, frame length, decoded content.
      leds = 8'h55; sb.push_back(8'h55);
      tick(1);
      check("t2_busy_rise", 32'(busy), 1);
      check("t2_tx_start", 32'(uart_tx), 0);
      tick(199);
      check("t2_busy_hold", 32'(busy), 1);
      tick(1);
      check("t2_busy_fall", 32'(busy), 0);
      check("t2_frames", 32'(frames_sent), 1);
      check("t2_sb_drain", 32'(sb.size()), 0);

      // Changes during a frame coalesce into one follow-up frame.
      do_reset();
      leds = 8'h01; sb.push_back(8'h01); sb.push_back(8'h55);
      tick(30); leds = 8'h05;
      tick(30); leds = 8'h15;
      tick(30); leds = 8'h55;
      tick(110);
      check("t3_busy_hold", 32'(busy), 1);
      tick(1);
      check("t3_gap_idle", 32'(busy), 0);
      check("t3_frames1", 32'(frames_sent), 1);
      check("t3_coal", 32'(coalesced_cnt), 2);
      tick(1);
      check("t3_gap_one", 32'(busy), 1);
      check("t3_tx_start2", 32'(uart_tx), 0);
      tick(200);
      check("t3_busy_fall", 32'(busy), 0);
      check("t3_frames2", 32'(frames_sent), 2);
      check("t3_coal_end", 32'(coalesced_cnt), 2);
      check("t3_sb_drain", 32'(sb.size()), 0);

      // Reset in the middle of a frame aborts it; a held value re-triggers.
      leds = 8'h3C;
      tick(75);
      rst = 1'b1;
      sb.delete();
      tick(1);
      check("t4_tx_idle", 32'(uart_tx), 1);
      check("t4_busy_clr", 32'(busy), 0);
      check("t4_frames_clr", 32'(frames_sent), 0);
      check("t4_coal_clr", 32'(coalesced_cnt), 0);
      rst = 1'b0;
      sb.push_back(8'h3C);
      tick(1);
      check("t4_retrigger", 32'(busy), 1);
      check("t4_tx_start", 32'(uart_tx), 0);
      tick(200);
      check("t4_busy_fall", 32'(busy), 0);
      check("t4_frames", 32'(frames_sent), 1);
      check("t4_sb_drain", 32'(sb.size()), 0);

      // Rapid toggling: saturation and only-held-values reporting.
      do_reset();
      sb_mode = 1'b1;
      foreach (seen[i]) seen[i] = 1'b0;
      prev = 8'h00;
      for (int i = 0; i < 400; i++) begin
         do v = 8'($urandom_range(1, 255)); while (v == prev);
         seen[v] = 1'b1;
         leds    = v;
         prev    = v;
         tick(5);
      end
      quiet = 0; waited = 0;
      while (quiet < 3 && waited < 2000) begin
         tick(1);
         waited++;
         quiet = busy ? 0 : quiet + 1;
      end
      check("t5_settle", 32'(quiet >= 3), 1);
      check("t5_last_frame", 32'(last_rx), 32'(prev));
      check("t5_coal_sat", 32'(coalesced_cnt), 'hFF);
      sb_mode = 1'b0;

      // Change landing on the final stop cycle goes through pending.
      do_reset();
      leds = 8'h0F; sb.push_back(8'h0F);
      tick(200);
      leds = 8'hF0; sb.push_back(8'hF0);
      tick(1);
      check("t6_idle", 32'(busy), 0);
      check("t6_frames1", 32'(frames_sent), 1);
      tick(1);
      check("t6_restart", 32'(busy), 1);
      check("t6_tx_start", 32'(uart_tx), 0);
      check("t6_coal", 32'(coalesced_cnt), 0);
      tick(200);
      check("t6_busy_fall", 32'(busy), 0);
      check("t6_frames2", 32'(frames_sent), 2);
      check("t6_coal_end", 32'(coalesced_cnt), 0);
      check("t6_sb_drain", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
